voice_slot_sequencer: RTL and testbench
=======================================

// Module: voice_slot_sequencer
// PURPOSE
//  Time-division sequencer for the voice datapath: the shared 4-bit adders, accumulator latches and wave ROM.
//  Steps NUM_SLOTS voice slots through 4 phases each and emits per-phase strobes to the datapath.
//  Also arbitrates the shared voice-parameter RAM between the slot datapath and CPU requests.
// PARAMETERS
//  NUM_SLOTS  16  voice slots per frame (power of two, >=2)
//  SLOT_BITS  4   width of SLOT; equals log2(NUM_SLOTS)
// PORTS
//  CK        in   1          clock; all state updates on rising edge
//  RST       in   1          asynchronous reset, active-high
//  RUN       in   1          1 = sequence slots; 0 = datapath halted
//  VOICE_EN  in   NUM_SLOTS  per-slot write-back enable; bit n = slot n
//  CPU_REQ   in   1          CPU parameter-RAM access request (level)
//  SLOT      out  SLOT_BITS  current slot number
//  PHASE     out  2          current phase within slot
//  SYNC      out  1          1 at slot 0 phase 0 while active
//  ADR_LD    out  1          phase 0: load param-RAM address / read params
//  ROM_OE    out  1          phase 1: wave ROM output enable
//  ACC_EN    out  1          phase 2: accumulator/adder latch enable
//  WB_WE     out  1          phase 3: write back, only if VOICE_EN[SLOT]
//  RAM_SEL   out  1          1 = CPU owns param RAM; 0 = datapath owns it
//  CPU_ACK   out  1          CPU access completed (4-phase handshake)
// BEHAVIOUR
//  Reset (RST=1): POS=0, ACT=0, FSM=IDLE. Every output is 0.
//  Position counter: POS = {SLOT,PHASE}, width SLOT_BITS+2. Active flag ACT.
//  Each rising edge, evaluated in this order:
//   1. RUN=0: ACT<=0, POS<=0.
//   2. Else RUN=1 & ACT=0: ACT<=1, POS stays 0.
//      This start is deferred while the FSM is in GNT1 or GNT2.
//   3. Else RUN=1 & ACT=1: POS<=POS+1, wrapping from NUM_SLOTS*4-1 to 0.
//  Decodes are combinational from registered POS/ACT/FSM, so they are valid in the same cycle:
//   - SLOT=POS[top:2], PHASE=POS[1:0].
//   - SYNC, ADR_LD, ROM_OE, ACC_EN and WB_WE are all gated by ACT.
//   - WB_WE = ACT & PHASE==3 & VOICE_EN[SLOT].
//   - With ACT=0: SLOT=0, PHASE=0, all strobes 0.
//  CPU FSM states: IDLE, GNT1, GNT2, ACKW.
//   IDLE -> GNT1 when CPU_REQ & (!ACT | (next POS lands on PHASE 2)).
//     When active, GNT1 therefore always coincides with PHASE 2.
//   GNT1 -> GNT2 unconditionally.
//   GNT2 -> ACKW unconditionally.
//   ACKW -> IDLE when CPU_REQ=0; stays in ACKW while CPU_REQ=1.
//   Outputs: RAM_SEL=1 in GNT1/GNT2; CPU_ACK=1 in ACKW only.
//   Guarantee: RAM_SEL is never 1 while ADR_LD=1.
//  Boundary cases:
//   - CPU_REQ dropped in GNT1/GNT2: access still completes; ACKW lasts 1 cycle, then IDLE.
//   - RUN falls mid-grant: grant sequence continues unchanged; counters clear per rule 1.
//   - RUN rises mid-grant: ACT stays 0 until FSM leaves GNT2, then step 2 applies.
//   - RST asserted mid-operation: immediate return to reset state; no ACK is issued.
//   - VOICE_EN may change any cycle; it is sampled combinationally in phase 3.
//   - Wrap: POS from slot NUM_SLOTS-1 phase 3 goes to slot 0 phase 0; SYNC=1 again.
// TESTING
//  T1: release RST, RUN=1 -> first edge gives SYNC=1 with SLOT=0 PHASE=0; SYNC repeats every 64 cycles;
//      SLOT sequence 0..15, each held 4 cycles.
//  T2: VOICE_EN=16'h0005 -> WB_WE=1 only at phase 3 of slots 0 and 2; ADR_LD/ROM_OE/ACC_EN fire once per slot.
//  T3: RUN=1, CPU_REQ raised at slot 5 phase 3 -> RAM_SEL=1 at slot 6 phases 2-3;
//      CPU_ACK=1 from slot 7 phase 0 until REQ drops, then IDLE next edge.
//  T4: RUN=0, CPU_REQ=1 -> RAM_SEL=1 on the next 2 cycles, then CPU_ACK=1; no strobes toggle.
//  T5: RUN raised while FSM in GNT1 (RUN=0 grant) -> ACT=1 one cycle after GNT2;
//      RAM_SEL & ADR_LD never both 1.
//  T6: RST pulse at slot 9 phase 2 during GNT1 -> all outputs 0 immediately;
//      restart shows SYNC at first RUN edge.

Source files
------------

// File: rtl/voice_slot_sequencer.sv
// Time-division slot/phase sequencer for the voice datapath, with arbitration of the shared
// voice-parameter RAM between the slot datapath and CPU requests.
module voice_slot_sequencer #(
   parameter int unsigned NUM_SLOTS = 16,
   parameter int unsigned SLOT_BITS = 4
) (
   input  logic                 CK,
   input  logic                 RST,
   input  logic                 RUN,
   input  logic [NUM_SLOTS-1:0] VOICE_EN,
   input  logic                 CPU_REQ,
   output logic [SLOT_BITS-1:0] SLOT,
   output logic [1:0]           PHASE,
   output logic                 SYNC,
   output logic                 ADR_LD,
   output logic                 ROM_OE,
   output logic                 ACC_EN,
   output logic                 WB_WE,
   output logic                 RAM_SEL,
   output logic                 CPU_ACK
);

   localparam int unsigned PosBits = SLOT_BITS + 2;
   localparam logic [PosBits-1:0] PosOne = PosBits'(1);

   typedef enum logic [1:0] {StIdle, StGnt1, StGnt2, StAckw} cpu_st_e;

   logic [PosBits-1:0] pos_q, pos_d;
   logic               act_q, act_d;
   cpu_st_e            st_q;
   logic               grant_start;
   logic               start_blocked;

   // Position width equals log2(NUM_SLOTS*4), so the increment wraps on its own.
   always_comb begin
      pos_d = pos_q;
      if (!RUN || !act_q) begin
         pos_d = '0;
      end else begin
         pos_d = pos_q + PosOne;
      end
   end

   // A grant may only begin where it cannot overlap phase 0 of any slot.
   assign grant_start = (st_q == StIdle) & CPU_REQ & (!act_q | (pos_d[1:0] == 2'd2));

   // Starting the datapath in the same edge a grant begins would put ADR_LD under RAM_SEL.
   assign start_blocked = grant_start | (st_q == StGnt1) | (st_q == StGnt2);
   assign act_d         = RUN & (act_q | !start_blocked);

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         pos_q   <= '0;
         act_q   <= 1'b0;
         st_q    <= StIdle;
         RAM_SEL <= 1'b0;
         CPU_ACK <= 1'b0;
      end else begin
         pos_q <= pos_d;
         act_q <= act_d;
         unique case (st_q)
            StIdle: begin
               if (grant_start) begin
                  st_q    <= StGnt1;
                  RAM_SEL <= 1'b1;
               end
            end
            StGnt1: begin
               st_q <= StGnt2;
            end
            StGnt2: begin
               st_q    <= StAckw;
               RAM_SEL <= 1'b0;
               CPU_ACK <= 1'b1;
            end
            StAckw: begin
               if (!CPU_REQ) begin
                  st_q    <= StIdle;
                  CPU_ACK <= 1'b0;
               end
            end
            default: begin
               st_q    <= StIdle;
               RAM_SEL <= 1'b0;
               CPU_ACK <= 1'b0;
            end
         endcase
      end
   end

   assign SLOT   = act_q ? pos_q[PosBits-1:2] : '0;
   assign PHASE  = act_q ? pos_q[1:0] : 2'd0;
   assign SYNC   = act_q & (pos_q == '0);
   assign ADR_LD = act_q & (pos_q[1:0] == 2'd0);
   assign ROM_OE = act_q & (pos_q[1:0] == 2'd1);
   assign ACC_EN = act_q & (pos_q[1:0] == 2'd2);
   assign WB_WE  = act_q & (pos_q[1:0] == 2'd3) & VOICE_EN[pos_q[PosBits-1:2]];

endmodule

// File: tb/tb_voice_slot_sequencer.sv
// Bench for voice_slot_sequencer: directed scenarios plus randomized traffic, all checked
// each cycle against an arithmetic reference model of slot position and CPU grant stage.
module tb_voice_slot_sequencer;

   localparam int NS = 16;
   localparam int NPOS = NS * 4;

   logic          CK = 1'b0;
   logic          RST = 1'b1;
   logic          RUN = 1'b0;
   logic [NS-1:0] VOICE_EN = '0;
   logic          CPU_REQ = 1'b0;
   logic [3:0]    SLOT;
   logic [1:0]    PHASE;
   logic          SYNC, ADR_LD, ROM_OE, ACC_EN, WB_WE, RAM_SEL, CPU_ACK;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: position as plain integer, active flag, grant stage
   // (0 = no access, 1 = first grant cycle, 2 = second grant cycle, 3 = acknowledging).
   int m_pos = 0;
   bit m_act = 1'b0;
   int m_stage = 0;

   voice_slot_sequencer #(.NUM_SLOTS(NS), .SLOT_BITS(4)) dut (
      .CK(CK), .RST(RST), .RUN(RUN), .VOICE_EN(VOICE_EN), .CPU_REQ(CPU_REQ),
      .SLOT(SLOT), .PHASE(PHASE), .SYNC(SYNC), .ADR_LD(ADR_LD), .ROM_OE(ROM_OE),
      .ACC_EN(ACC_EN), .WB_WE(WB_WE), .RAM_SEL(RAM_SEL), .CPU_ACK(CPU_ACK)
   );

   always #5 CK = ~CK;

   task automatic model_reset();
      m_pos = 0;
      m_act = 1'b0;
      m_stage = 0;
   endtask

   task automatic model_edge();
      int  nxt;
      bit  gs;
      bit  blocked;
      nxt = (RUN && m_act) ? (m_pos + 1) % NPOS : 0;
      gs = (m_stage == 0) && CPU_REQ && (!m_act || (nxt % 4 == 2));
      blocked = gs || m_stage == 1 || m_stage == 2;
      case (m_stage)
         0: m_stage = gs ? 1 : 0;
         1: m_stage = 2;
         2: m_stage = 3;
         default: m_stage = CPU_REQ ? 3 : 0;
      endcase
      m_act = RUN && (m_act || !blocked);
      m_pos = nxt;
   endtask

   function automatic logic [12:0] model_out();
      int slot;
      int ph;
      slot = m_act ? m_pos / 4 : 0;
      ph   = m_act ? m_pos % 4 : 0;
      return {4'(slot), 2'(ph),
              m_act && m_pos == 0,
              m_act && ph == 0,
              m_act && ph == 1,
              m_act && ph == 2,
              m_act && ph == 3 && VOICE_EN[slot],
              m_stage == 1 || m_stage == 2,
              m_stage == 3};
   endfunction

   task automatic check(input string tag);
      logic [12:0] obs;
      logic [12:0] exp;
      obs = {SLOT, PHASE, SYNC, ADR_LD, ROM_OE, ACC_EN, WB_WE, RAM_SEL, CPU_ACK};
      exp = model_out();
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b (model pos=%0d act=%0b stage=%0d)",
                tag, obs, exp, m_pos, m_act, m_stage);
      end
      vectors++;
      assert (!(RAM_SEL === 1'b1 && ADR_LD === 1'b1)) else begin
         miscompares++;
         $error("FAIL %s_ramsel_vs_adrld: observed RAM_SEL=%b ADR_LD=%b expected not both 1",
                tag, RAM_SEL, ADR_LD);
      end
   endtask

   task automatic step(input string tag);
      @(posedge CK);
      model_edge();
      #1;
      check(tag);
   endtask

   task automatic steps(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic reset_pulse(input string tag);
      RST = 1'b1;
      #2;
      model_reset();
      check(tag);
      @(negedge CK);
      RST = 1'b0;
   endtask

   task automatic run_to(input string tag, input int target);
      for (int i = 0; i < 2 * NPOS && !(m_act && m_pos == target); i++) step(tag);
   endtask

   initial begin
      // Reset state
      reset_pulse("reset");

      // T1: run from reset, several frames with wrap and SYNC repeat
      RUN = 1'b1;
      steps("t1_run", 2 * NPOS + 3);

      // T2: write-back only for slots 0 and 2
      VOICE_EN = 16'h0005;
      steps("t2_voice_en", NPOS + 2);

      // T3: CPU request while active, raised at slot 5 phase 3
      VOICE_EN = 16'hA5C3;
      run_to("t3_seek", 5 * 4 + 3);
      CPU_REQ = 1'b1;
      steps("t3_grant", 12);
      CPU_REQ = 1'b0;
      steps("t3_release", 4);

      // T4: CPU request while halted
      RUN = 1'b0;
      steps("t4_halt", 2);
      CPU_REQ = 1'b1;
      steps("t4_grant", 6);
      CPU_REQ = 1'b0;
      steps("t4_release", 3);

      // T5: RUN rises while the halted grant is in progress
      CPU_REQ = 1'b1;
      step("t5_gnt1");
      RUN = 1'b1;
      CPU_REQ = 1'b0;
      steps("t5_run_mid_grant", 10);

      // Request dropped during the grant: single ACK cycle
      run_to("drop_seek", 3 * 4 + 1);
      CPU_REQ = 1'b1;
      step("drop_gnt1");
      CPU_REQ = 1'b0;
      steps("drop_finish", 5);

      // T6: reset during GNT1 at slot 9 phase 2, then restart
      run_to("t6_seek", 9 * 4 + 1);
      CPU_REQ = 1'b1;
      step("t6_gnt1");
      CPU_REQ = 1'b0;
      reset_pulse("t6_reset");
      steps("t6_restart", 6);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         VOICE_EN = NS'($urandom);
         if ($urandom_range(15) == 0) RUN = ~RUN;
         if ($urandom_range(7) == 0) CPU_REQ = ~CPU_REQ;
         if ($urandom_range(499) == 0) begin
            reset_pulse("rand_reset");
         end else begin
            step("rand");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
